// File: rtl/parl_add_tree_if.sv
// rtl/parl_add_tree_if.sv - operand/result handshake bundle for parl_add_tree
interface parl_add_tree_if #(
    parameter int NUM_OPERANDS  = 5,
    parameter int OPERAND_WIDTH = 19,
    parameter int OUTPUT_WIDTH  = 22
);
    logic                                  parl_add_tree_in_vld_i;
    logic                                  parl_add_tree_in_rdy_o;
    logic [NUM_OPERANDS*OPERAND_WIDTH-1:0] parl_add_tree_in_i;
    logic                                  parl_add_tree_out_vld_o;
    logic                                  parl_add_tree_out_rdy_i;
    logic [OUTPUT_WIDTH-1:0]               parl_add_tree_out_o;
    logic                                  parl_add_tree_ovf_o;

    modport slave (
        input  parl_add_tree_in_vld_i,
        input  parl_add_tree_in_i,
        input  parl_add_tree_out_rdy_i,
        output parl_add_tree_in_rdy_o,
        output parl_add_tree_out_vld_o,
        output parl_add_tree_out_o,
        output parl_add_tree_ovf_o
    );

    modport master (
        output parl_add_tree_in_vld_i,
        output parl_add_tree_in_i,
        output parl_add_tree_out_rdy_i,
        input  parl_add_tree_in_rdy_o,
        input  parl_add_tree_out_vld_o,
        input  parl_add_tree_out_o,
        input  parl_add_tree_ovf_o
    );
endinterface

// File: rtl/parl_add_tree.sv
// rtl/parl_add_tree.sv - pipelined signed adder tree with global stall and saturating/wrapping resize
module parl_add_tree #(
    parameter int NUM_OPERANDS  = 5,
    parameter int OPERAND_WIDTH = 19,
    parameter int OUTPUT_WIDTH  = 22,
    parameter bit SATURATE      = 1'b1
) (
    input  logic           parl_add_tree_clk,
    input  logic           parl_add_tree_rst_b,
    parl_add_tree_if.slave bus
);
    localparam int LAT    = $clog2(NUM_OPERANDS);
    localparam int FULL_W = OPERAND_WIDTH + LAT;
    localparam int NREG   = (LAT > 1) ? LAT - 1 : 1;

    typedef logic signed [FULL_W-1:0] term_t;

    function automatic int terms(input int lvl);
        int c;
        c = NUM_OPERANDS;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

    // Every tree level is carried at FULL_W; pair sums never exceed their natural width + 1.
    term_t                          r_lvl [NREG][NUM_OPERANDS];
    term_t                          w_lvl [LAT][NUM_OPERANDS];
    term_t                          w_nxt [NREG][NUM_OPERANDS];
    term_t                          w_fin;
    logic [LAT-1:0]                 r_vld;
    logic signed [OUTPUT_WIDTH-1:0] r_out;
    logic signed [OUTPUT_WIDTH-1:0] w_res;
    logic                           r_ovf;
    logic                           w_ovf;
    logic                           w_en;

    assign w_en = !(r_vld[LAT-1] && !bus.parl_add_tree_out_rdy_i);

    always_comb begin
        for (int l = 0; l < LAT; l++)
            for (int k = 0; k < NUM_OPERANDS; k++)
                w_lvl[l][k] = '0;
        for (int k = 0; k < NUM_OPERANDS; k++)
            w_lvl[0][k] = FULL_W'($signed(bus.parl_add_tree_in_i[k*OPERAND_WIDTH +: OPERAND_WIDTH]));
        for (int l = 1; l < LAT; l++)
            for (int k = 0; k < NUM_OPERANDS; k++)
                w_lvl[l][k] = r_lvl[l-1][k];
    end

    always_comb begin
        for (int l = 0; l < NREG; l++)
            for (int k = 0; k < NUM_OPERANDS; k++)
                w_nxt[l][k] = '0;
        for (int l = 0; l < LAT - 1; l++) begin
            for (int k = 0; k < NUM_OPERANDS; k++) begin
                int i0, i1;
                i0 = (2 * k < NUM_OPERANDS) ? 2 * k : 0;
                i1 = (2 * k + 1 < NUM_OPERANDS) ? 2 * k + 1 : i0;
                if (2 * k + 1 < terms(l))
                    w_nxt[l][k] = w_lvl[l][i0] + w_lvl[l][i1];
                else if (2 * k < terms(l))
                    w_nxt[l][k] = w_lvl[l][i0];
            end
        end
    end

    // The last level always holds exactly two terms; their sum is resized in the same stage.
    assign w_fin = w_lvl[LAT-1][0] + w_lvl[LAT-1][1];

    generate
        if (OUTPUT_WIDTH >= FULL_W) begin : g_ext
            assign w_res = OUTPUT_WIDTH'(w_fin);
            assign w_ovf = 1'b0;
        end else begin : g_narrow
            logic [FULL_W-OUTPUT_WIDTH:0] w_hi;
            assign w_hi  = w_fin[FULL_W-1:OUTPUT_WIDTH-1];
            assign w_ovf = (|w_hi) && !(&w_hi);
            if (SATURATE) begin : g_sat
                assign w_res = w_ovf ? {w_fin[FULL_W-1], {(OUTPUT_WIDTH-1){~w_fin[FULL_W-1]}}}
                                     : w_fin[OUTPUT_WIDTH-1:0];
            end else begin : g_wrap
                assign w_res = w_fin[OUTPUT_WIDTH-1:0];
            end
        end
    endgenerate

    always_ff @(posedge parl_add_tree_clk) begin
        if (!parl_add_tree_rst_b) begin
            r_vld <= '0;
            r_out <= '0;
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_vld[0] <= bus.parl_add_tree_in_vld_i;
            for (int i = LAT - 1; i > 0; i--) r_vld[i] <= r_vld[i-1];
            r_out <= w_res;
            r_ovf <= w_ovf;
        end
    end

    always_ff @(posedge parl_add_tree_clk) begin
        if (w_en) r_lvl <= w_nxt;
    end

    assign bus.parl_add_tree_in_rdy_o  = w_en;
    assign bus.parl_add_tree_out_vld_o = r_vld[LAT-1];
    assign bus.parl_add_tree_out_o     = r_out;
    assign bus.parl_add_tree_ovf_o     = r_ovf;
endmodule

// File: tb/tb_parl_add_tree.sv
// tb/tb_parl_add_tree.sv - self-checking bench for parl_add_tree (wide, saturating and wrapping builds)
module tb_parl_add_tree;
    localparam int N   = 5;
    localparam int W   = 19;
    localparam int OW  = 22;
    localparam int OWN = 20;
    localparam int LAT = 3;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    parl_add_tree_if #(.NUM_OPERANDS(N), .OPERAND_WIDTH(W), .OUTPUT_WIDTH(OW))  bus_d ();
    parl_add_tree_if #(.NUM_OPERANDS(N), .OPERAND_WIDTH(W), .OUTPUT_WIDTH(OWN)) bus_s ();
    parl_add_tree_if #(.NUM_OPERANDS(N), .OPERAND_WIDTH(W), .OUTPUT_WIDTH(OWN)) bus_w ();

    parl_add_tree #(.NUM_OPERANDS(N), .OPERAND_WIDTH(W), .OUTPUT_WIDTH(OW), .SATURATE(1'b1)) u_dut (
        .parl_add_tree_clk(clk), .parl_add_tree_rst_b(rst_b), .bus(bus_d));
    parl_add_tree #(.NUM_OPERANDS(N), .OPERAND_WIDTH(W), .OUTPUT_WIDTH(OWN), .SATURATE(1'b1)) u_sat (
        .parl_add_tree_clk(clk), .parl_add_tree_rst_b(rst_b), .bus(bus_s));
    parl_add_tree #(.NUM_OPERANDS(N), .OPERAND_WIDTH(W), .OUTPUT_WIDTH(OWN), .SATURATE(1'b0)) u_wrap (
        .parl_add_tree_clk(clk), .parl_add_tree_rst_b(rst_b), .bus(bus_w));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: accepted sums with the number of enabled edges each has seen since acceptance.
    longint sums[$];
    int     ages[$];

    logic        obs_vld, obs_rdy, obs_ovf, obs_sovf, obs_wovf;
    logic [21:0] obs_out;
    logic [19:0] obs_sout, obs_wout;

    typedef struct {
        logic [N-1:0][W-1:0] op;
        logic [21:0] e22;
        logic [19:0] es;
        bit          os;
        logic [19:0] ew;
        bit          ow;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic longint resize(input longint s, input int ow, input bit sat, output bit ovf);
        longint mx, mn, m, v;
        mx  = (longint'(1) <<< (ow - 1)) - 1;
        mn  = -(longint'(1) <<< (ow - 1));
        m   = (longint'(1) <<< ow) - 1;
        ovf = (s > mx) || (s < mn);
        v   = s;
        if (ovf && sat) v = (s > mx) ? mx : mn;
        return v & m;
    endfunction

    function automatic logic [N*W-1:0] rep(input logic [W-1:0] v);
        return {N{v}};
    endfunction

    function automatic longint op_sum(input logic [N*W-1:0] ops);
        longint s;
        s = 0;
        for (int k = 0; k < N; k++) s += longint'($signed(ops[k*W +: W]));
        return s;
    endfunction

    task automatic add_vec(input logic [W-1:0] a, b, c, d, e, input logic [21:0] e22,
                           input logic [19:0] es, input bit os, input logic [19:0] ew, input bit ow);
        vec_t v;
        v.op[0] = a; v.op[1] = b; v.op[2] = c; v.op[3] = d; v.op[4] = e;
        v.e22 = e22; v.es = es; v.os = os; v.ew = ew; v.ow = ow;
        tbl.push_back(v);
    endtask

    // One clock cycle: drive after the falling edge, compare against the model, then advance the model.
    task automatic cycle(input bit rst, input bit vld, input logic [N*W-1:0] ops, input bit ordy);
        bit exp_vld, exp_en, o;
        longint e;
        @(negedge clk);
        rst_b = !rst;
        bus_d.parl_add_tree_in_vld_i = vld; bus_d.parl_add_tree_in_i = ops; bus_d.parl_add_tree_out_rdy_i = ordy;
        bus_s.parl_add_tree_in_vld_i = vld; bus_s.parl_add_tree_in_i = ops; bus_s.parl_add_tree_out_rdy_i = ordy;
        bus_w.parl_add_tree_in_vld_i = vld; bus_w.parl_add_tree_in_i = ops; bus_w.parl_add_tree_out_rdy_i = ordy;
        #1;
        exp_vld = (sums.size() != 0) && (ages[0] == LAT - 1);
        exp_en  = !(exp_vld && !ordy);
        chk("out_vld", longint'(bus_d.parl_add_tree_out_vld_o), longint'(exp_vld));
        chk("out_vld_sat", longint'(bus_s.parl_add_tree_out_vld_o), longint'(exp_vld));
        chk("out_vld_wrap", longint'(bus_w.parl_add_tree_out_vld_o), longint'(exp_vld));
        chk("in_rdy", longint'(bus_d.parl_add_tree_in_rdy_o), longint'(exp_en));
        if (exp_vld) begin
            e = resize(sums[0], OW, 1'b1, o);
            chk("out22", longint'(bus_d.parl_add_tree_out_o), e);
            chk("ovf22", longint'(bus_d.parl_add_tree_ovf_o), longint'(o));
            e = resize(sums[0], OWN, 1'b1, o);
            chk("out_sat", longint'(bus_s.parl_add_tree_out_o), e);
            chk("ovf_sat", longint'(bus_s.parl_add_tree_ovf_o), longint'(o));
            e = resize(sums[0], OWN, 1'b0, o);
            chk("out_wrap", longint'(bus_w.parl_add_tree_out_o), e);
            chk("ovf_wrap", longint'(bus_w.parl_add_tree_ovf_o), longint'(o));
        end
        obs_vld  = bus_d.parl_add_tree_out_vld_o; obs_rdy  = bus_d.parl_add_tree_in_rdy_o;
        obs_out  = bus_d.parl_add_tree_out_o;     obs_ovf  = bus_d.parl_add_tree_ovf_o;
        obs_sout = bus_s.parl_add_tree_out_o;     obs_sovf = bus_s.parl_add_tree_ovf_o;
        obs_wout = bus_w.parl_add_tree_out_o;     obs_wovf = bus_w.parl_add_tree_ovf_o;
        if (rst) begin
            sums.delete();
            ages.delete();
        end else if (exp_en) begin
            if (exp_vld) begin
                void'(sums.pop_front());
                void'(ages.pop_front());
            end
            for (int i = 0; i < ages.size(); i++) ages[i] = ages[i] + 1;
            if (vld) begin
                sums.push_back(op_sum(ops));
                ages.push_back(0);
            end
        end
    endtask

    initial begin
        int lat;
        bit found;
        logic [N*W-1:0] ops;

        bus_d.parl_add_tree_in_vld_i = 1'b0; bus_d.parl_add_tree_in_i = '0; bus_d.parl_add_tree_out_rdy_i = 1'b1;
        bus_s.parl_add_tree_in_vld_i = 1'b0; bus_s.parl_add_tree_in_i = '0; bus_s.parl_add_tree_out_rdy_i = 1'b1;
        bus_w.parl_add_tree_in_vld_i = 1'b0; bus_w.parl_add_tree_in_i = '0; bus_w.parl_add_tree_out_rdy_i = 1'b1;

        add_vec(19'h02FFF, 19'h02FFF, 19'h02FFF, 19'h02FFF, 19'h02FFF, 22'h00EFFB, 20'h0EFFB, 0, 20'h0EFFB, 0);
        add_vec(19'h01000, 19'h01000, 19'h01000, 19'h01000, 19'h01000, 22'h005000, 20'h05000, 0, 20'h05000, 0);
        add_vec(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 22'h3FFFFB, 20'hFFFFB, 0, 20'hFFFFB, 0);
        add_vec(19'h00001, 19'h7FFFF, 19'h00002, 19'h7FFFE, 19'h00007, 22'h000007, 20'h00007, 0, 20'h00007, 0);
        add_vec(19'h3FFFF, 19'h3FFFF, 19'h3FFFF, 19'h3FFFF, 19'h3FFFF, 22'h13FFFB, 20'h7FFFF, 1, 20'h3FFFB, 1);
        add_vec(19'h40000, 19'h40000, 19'h40000, 19'h40000, 19'h40000, 22'h2C0000, 20'h80000, 1, 20'hC0000, 1);

        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("reset_out", longint'(obs_out), 0);
        chk("reset_ovf", longint'(obs_ovf), 0);
        chk("reset_vld", longint'(obs_vld), 0);

        // Directed vectors, one at a time, with latency measured from the accepting cycle.
        for (int t = 0; t < tbl.size(); t++) begin
            cycle(1'b0, 1'b1, tbl[t].op, 1'b1);
            found = 1'b0;
            lat   = 0;
            for (int c = 1; c <= 8 && !found; c++) begin
                cycle(1'b0, 1'b0, '0, 1'b1);
                if (obs_vld) begin
                    found = 1'b1;
                    lat   = c;
                end
            end
            chk("tbl_latency", longint'(lat), longint'(LAT));
            chk("tbl_out22", longint'(obs_out), longint'(tbl[t].e22));
            chk("tbl_ovf22", longint'(obs_ovf), 0);
            chk("tbl_out_sat", longint'(obs_sout), longint'(tbl[t].es));
            chk("tbl_ovf_sat", longint'(obs_sovf), longint'(tbl[t].os));
            chk("tbl_out_wrap", longint'(obs_wout), longint'(tbl[t].ew));
            chk("tbl_ovf_wrap", longint'(obs_wovf), longint'(tbl[t].ow));
        end

        // Back-to-back feed, four-cycle stall with a vector waiting at the input, then release.
        cycle(1'b0, 1'b1, rep(19'h01000), 1'b1);
        cycle(1'b0, 1'b1, rep(19'h02000), 1'b1);
        cycle(1'b0, 1'b1, rep(19'h03000), 1'b1);
        for (int s = 0; s < 4; s++) begin
            cycle(1'b0, 1'b1, rep(19'h00100), 1'b0);
            chk("stall_vld", longint'(obs_vld), 1);
            chk("stall_out", longint'(obs_out), 22'h005000);
            chk("stall_ovf", longint'(obs_ovf), 0);
            chk("stall_in_rdy", longint'(obs_rdy), 0);
        end
        cycle(1'b0, 1'b1, rep(19'h00100), 1'b1);
        chk("release_out0", longint'(obs_out), 22'h005000);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("release_out1", longint'(obs_out), 22'h00A000);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("release_out2", longint'(obs_out), 22'h00F000);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("release_out3", longint'(obs_out), 22'h000500);
        chk("release_vld3", longint'(obs_vld), 1);

        // Reset pulse with two vectors in flight: nothing may emerge afterwards.
        cycle(1'b0, 1'b1, rep(19'h01000), 1'b1);
        cycle(1'b0, 1'b1, rep(19'h02000), 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("rst_pulse_vld", longint'(obs_vld), 0);
        chk("rst_pulse_out", longint'(obs_out), 0);
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, rep(19'h02FFF), 1'b1);
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("post_rst_out", longint'(obs_out), 22'h00EFFB);
        chk("post_rst_vld", longint'(obs_vld), 1);

        // Random traffic with random back-pressure, checked cycle by cycle against the model.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 5))
                    0:       ops[k*W +: W] = 19'h3FFFF;
                    1:       ops[k*W +: W] = 19'h40000;
                    2:       ops[k*W +: W] = W'($urandom_range(0, 255));
                    default: ops[k*W +: W] = W'($urandom());
                endcase
            end
            cycle(1'b0, ($urandom_range(0, 9) < 7), ops, ($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < 10; c++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("drained", longint'(sums.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
